// File: rtl/regfile_write_arbiter.sv
// Two-client round-robin write arbiter in front of a register file write port.
// Optional macro REGFILE_ARB_ZERO_FILTER_EN suppresses RegWrite for register-0 grants.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  output logic              GntA,
  output logic              GntB,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              LastGnt
);

  // Handshake: a client holds Req/Addr/Data stable until it samples its Gnt
  // high at a rising edge; the request is consumed on that edge. Gnt is a
  // one-cycle pulse, and a client whose Gnt is high is not eligible, so the
  // same client is never granted on two consecutive edges.

  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              reg_write_q, reg_write_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic elig_a;
  logic elig_b;
  logic pick_a;
  logic pick_b;
  logic win_addr_zero;

  always_comb begin
    elig_a = ReqA && !gnt_a_q && !Hold;
    elig_b = ReqB && !gnt_b_q && !Hold;
    // LastGnt=1 means B was served last, so A takes the tie.
    pick_a = elig_a && (!elig_b || last_gnt_q);
    pick_b = elig_b && !pick_a;
  end

  always_comb begin
    gnt_a_d          = 1'b0;
    gnt_b_d          = 1'b0;
    reg_write_d      = 1'b0;
    last_gnt_d       = last_gnt_q;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    win_addr_zero    = 1'b0;

    if (pick_a) begin
      gnt_a_d          = 1'b1;
      last_gnt_d       = 1'b0;
      write_register_d = AddrA;
      write_data_d     = DataA;
      win_addr_zero    = (AddrA == '0);
    end else if (pick_b) begin
      gnt_b_d          = 1'b1;
      last_gnt_d       = 1'b1;
      write_register_d = AddrB;
      write_data_d     = DataB;
      win_addr_zero    = (AddrB == '0);
    end

`ifdef REGFILE_ARB_ZERO_FILTER_EN
    reg_write_d = (pick_a || pick_b) && !win_addr_zero;
`else
    reg_write_d = pick_a || pick_b;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gnt_a_q          <= 1'b0;
      gnt_b_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      last_gnt_q       <= 1'b1;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      gnt_a_q          <= gnt_a_d;
      gnt_b_q          <= gnt_b_d;
      reg_write_q      <= reg_write_d;
      last_gnt_q       <= last_gnt_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign GntA          = gnt_a_q;
  assign GntB          = gnt_b_q;
  assign RegWrite      = reg_write_q;
  assign LastGnt       = last_gnt_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with a tiny register file
// model fed from the arbiter's write port.
module tb_regfile_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Hold;
  logic              ReqA, ReqB;
  logic [ADDR_W-1:0] AddrA, AddrB;
  logic [DATA_W-1:0] DataA, DataB;
  logic              GntA, GntB;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic              LastGnt;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DATA_W-1:0] rf [0:(1<<ADDR_W)-1];

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .ReqA(ReqA), .ReqB(ReqB),
    .AddrA(AddrA), .AddrB(AddrB),
    .DataA(DataA), .DataB(DataB),
    .GntA(GntA), .GntB(GntB),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .LastGnt(LastGnt)
  );

  // clock / reset block
  always #5 Clk = ~Clk;

  // register file model: r0 is hardwired to zero
  always @(posedge Clk) begin
    if (RegWrite && WriteRegister != '0) rf[WriteRegister] <= WriteData;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ga, input logic gb, input logic rw);
    chk({tag, ".gnt_a"}, 64'(GntA), 64'(ga));
    chk({tag, ".gnt_b"}, 64'(GntB), 64'(gb));
    chk({tag, ".reg_write"}, 64'(RegWrite), 64'(rw));
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, ".write_register"}, 64'(WriteRegister), 64'(a));
    chk({tag, ".write_data"}, 64'(WriteData), 64'(d));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk_wr("reset", '0, '0);
    chk("reset.last_gnt", 64'(LastGnt), 64'd1);
    step();
    Reset = 1'b0;
  endtask

  logic exp_zero_rw;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rf[i] = '0;
    Reset = 1'b1; Hold = 1'b0;
    ReqA = 1'b0; ReqB = 1'b0;
    AddrA = '0; AddrB = '0; DataA = '0; DataB = '0;
`ifdef REGFILE_ARB_ZERO_FILTER_EN
    exp_zero_rw = 1'b0;
`else
    exp_zero_rw = 1'b1;
`endif
    #2;
    do_reset();
    step();
    chk_out("idle", 1'b0, 1'b0, 1'b0);

    // single client A: r2 <= 42
    ReqA = 1'b1; AddrA = 5'd2; DataA = 32'd42;
    step();
    chk_out("single", 1'b1, 1'b0, 1'b1);
    chk_wr("single", 5'd2, 32'd42);
    chk("single.last_gnt", 64'(LastGnt), 64'd0);
    ReqA = 1'b0;
    step();
    chk_out("single_end", 1'b0, 1'b0, 1'b0);
    chk_wr("single_hold", 5'd2, 32'd42);
    chk("single.r2", 64'(rf[2]), 64'd42);

    // contention right after reset: A first, then B
    do_reset();
    ReqA = 1'b1; AddrA = 5'd3; DataA = 32'd60;
    ReqB = 1'b1; AddrB = 5'd4; DataB = 32'd15;
    step();
    chk_out("cont1", 1'b1, 1'b0, 1'b1);
    chk_wr("cont1", 5'd3, 32'd60);
    ReqA = 1'b0;
    step();
    chk_out("cont2", 1'b0, 1'b1, 1'b1);
    chk_wr("cont2", 5'd4, 32'd15);
    ReqB = 1'b0;
    step();
    chk_out("cont_end", 1'b0, 1'b0, 1'b0);
    chk("cont.r3", 64'(rf[3]), 64'd60);
    chk("cont.r4", 64'(rf[4]), 64'd15);

    // continuous contention: A,B,A,B,A,B (LastGnt=1 here)
    ReqA = 1'b1; AddrA = 5'd6; DataA = 32'd100;
    ReqB = 1'b1; AddrB = 5'd7; DataB = 32'd200;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1, 1'b1);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    step();
    chk_out("rr_end", 1'b0, 1'b0, 1'b0);
    chk("rr.r6", 64'(rf[6]), 64'd100);
    chk("rr.r7", 64'(rf[7]), 64'd200);

    // Hold for 3 cycles with B pending
    Hold = 1'b1;
    ReqB = 1'b1; AddrB = 5'd5; DataB = 32'd25;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0);
    end
    chk_wr("hold_keep", 5'd7, 32'd200);
    Hold = 1'b0;
    step();
    chk_out("hold_rel", 1'b0, 1'b1, 1'b1);
    chk_wr("hold_rel", 5'd5, 32'd25);
    ReqB = 1'b0;
    step();
    chk("hold.r5", 64'(rf[5]), 64'd25);

    // write to register 0
    ReqA = 1'b1; AddrA = 5'd0; DataA = 32'd15;
    step();
    chk_out("zero", 1'b1, 1'b0, exp_zero_rw);
    ReqA = 1'b0;
    step();
    chk_out("zero_end", 1'b0, 1'b0, 1'b0);
    chk("zero.r0", 64'(rf[0]), 64'd0);

    // same register from both clients: LastGnt=0, so B first, A's write wins
    ReqA = 1'b1; AddrA = 5'd9; DataA = 32'd11;
    ReqB = 1'b1; AddrB = 5'd9; DataB = 32'd22;
    step();
    chk_out("same1", 1'b0, 1'b1, 1'b1);
    chk_wr("same1", 5'd9, 32'd22);
    ReqB = 1'b0;
    step();
    chk_out("same2", 1'b1, 1'b0, 1'b1);
    chk_wr("same2", 5'd9, 32'd11);
    ReqA = 1'b0;
    step();
    chk("same.r9", 64'(rf[9]), 64'd11);

    // reset in the cycle of a grant: cancelled, then granted exactly once
    ReqA = 1'b1; AddrA = 5'd8; DataA = 32'd99;
    step();
    chk_out("rst_grant", 1'b1, 1'b0, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0);
    chk_wr("rst_mid", '0, '0);
    step();
    Reset = 1'b0;
    chk("rst.r8_cancel", 64'(rf[8]), 64'd0);
    step();
    chk_out("rst_regrant", 1'b1, 1'b0, 1'b1);
    chk_wr("rst_regrant", 5'd8, 32'd99);
    ReqA = 1'b0;
    step();
    chk_out("rst_once1", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst_once2", 1'b0, 1'b0, 1'b0);
    chk("rst.r8", 64'(rf[8]), 64'd99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the register address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the write data width.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Hold, input, 1 bit: while high, no new grants are issued.
REQ-006 The block SHALL have ports ReqA and ReqB, input, 1 bit each: write request from client A and client B.
REQ-007 The block SHALL have ports AddrA and AddrB, input, ADDR_W bits each: target register of each client.
REQ-008 The block SHALL have ports DataA and DataB, input, DATA_W bits each: write data of each client.
REQ-009 The block SHALL have ports GntA and GntB, output, 1 bit each: one-cycle acceptance pulse to each client.
REQ-010 The block SHALL have port WriteRegister, output, ADDR_W bits: drives the register file write address.
REQ-011 The block SHALL have port WriteData, output, DATA_W bits: drives the register file write data.
REQ-012 The block SHALL have port RegWrite, output, 1 bit: drives the register file write enable.
REQ-013 The block SHALL have port LastGnt, output, 1 bit: 0 = client A granted last, 1 = client B granted last.

Function
REQ-014 Handshake: each client SHALL hold Req, Addr and Data stable until it samples its Gnt high at a rising edge; the request is consumed on that edge.
REQ-015 Grant decision: at each rising edge with Hold=0, the arbiter SHALL select one eligible requester, with the selection registered.
REQ-016 Eligibility: a client SHALL be eligible only if its Req=1 and its Gnt is currently 0, so a client is never granted on two consecutive edges.
REQ-017 Arbitration SHALL be round-robin: if both clients are eligible, the client not indicated by LastGnt wins.
REQ-018 On a grant, at the same edge, Gnt of the winner SHALL be set to 1, WriteRegister/WriteData SHALL load the winner's Addr/Data, RegWrite SHALL be set to 1, and LastGnt SHALL be updated.
REQ-019 Latency: a request present before edge N SHALL produce RegWrite=1 in cycle N..N+1, and the register file SHALL commit the write at edge N+1.
REQ-020 Gnt and RegWrite SHALL each be high for exactly one cycle per grant; with no grant they SHALL return to 0 at the next edge.
REQ-021 WriteRegister and WriteData SHALL hold their last values when no grant occurs.
REQ-022 Hold=1 SHALL suppress the grant at that edge and drive Gnt=0 and RegWrite=0; pending Req SHALL be served after Hold falls, with no request lost.
REQ-023 With both clients requesting continuously, grants SHALL alternate A,B,A,B at one grant per cycle.
REQ-024 Both clients targeting the same register on successive grants SHALL cause both writes to be issued in grant order, with the later write winning.

Reset
REQ-025 Reset=1 SHALL immediately force GntA=0, GntB=0, RegWrite=0, WriteRegister=0, WriteData=0 and LastGnt=1, so that A wins the first tie.
REQ-026 Reset asserted mid-grant SHALL cancel that grant; the client SHALL see no Gnt pulse and SHALL keep requesting.

Configuration
REQ-027 Macro REGFILE_ARB_ZERO_FILTER_EN SHALL control how writes to register 0 are handled.
REQ-028 With REGFILE_ARB_ZERO_FILTER_EN defined, a grant whose Addr=0 SHALL pulse Gnt normally but keep RegWrite=0.
REQ-029 Without REGFILE_ARB_ZERO_FILTER_EN, register-0 writes SHALL pass through with RegWrite=1; the register file is then responsible for ignoring them.

Verification
REQ-030 Single client: ReqA=1, AddrA=2, DataA=42 -> GntA and RegWrite pulse for one cycle, WriteRegister=2, WriteData=42; a read of r2 afterwards returns 42.
REQ-031 Contention after reset: ReqA=1 (r3, 60) and ReqB=1 (r4, 15) together -> A is granted first, B on the next edge; r3=60 and r4=15.
REQ-032 Continuous contention for 6 cycles -> grant sequence is A,B,A,B,A,B; no cycle without RegWrite.
REQ-033 Hold=1 for 3 cycles with ReqB=1 (r5, 25) -> no Gnt and no RegWrite during Hold; GntB at the first edge after Hold=0; r5=25.
REQ-034 ReqA with AddrA=0, DataA=15 -> GntA pulses; RegWrite=0 with the macro defined, RegWrite=1 without; r0 reads 0 in both cases.
REQ-035 Reset asserted in the cycle of a grant -> outputs are zero immediately; after release the pending request is granted exactly once.
